// File: rtl/axi_lite_icb_bridge.sv
// AXI-Lite slave to ICB master bridge: one-deep AW/W/AR buffers feeding a single
// ICB master port with at most one command outstanding; reads and writes alternate on conflict.
module axi_lite_icb_bridge #(
    parameter real        simulation_delay = 1,
    parameter logic [1:0] slverr_code      = 2'b10
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic [31:0] s_axi_awaddr,
    input  logic [2:0]  s_axi_awprot,
    input  logic        s_axi_awvalid,
    output logic        s_axi_awready,
    input  logic [31:0] s_axi_wdata,
    input  logic [3:0]  s_axi_wstrb,
    input  logic        s_axi_wvalid,
    output logic        s_axi_wready,
    output logic [1:0]  s_axi_bresp,
    output logic        s_axi_bvalid,
    input  logic        s_axi_bready,
    input  logic [31:0] s_axi_araddr,
    input  logic [2:0]  s_axi_arprot,
    input  logic        s_axi_arvalid,
    output logic        s_axi_arready,
    output logic [31:0] s_axi_rdata,
    output logic [1:0]  s_axi_rresp,
    output logic        s_axi_rvalid,
    input  logic        s_axi_rready,
    output logic [31:0] m_icb_cmd_addr,
    output logic        m_icb_cmd_read,
    output logic [31:0] m_icb_cmd_wdata,
    output logic [3:0]  m_icb_cmd_wmask,
    output logic        m_icb_cmd_valid,
    input  logic        m_icb_cmd_ready,
    input  logic [31:0] m_icb_rsp_rdata,
    input  logic        m_icb_rsp_err,
    input  logic        m_icb_rsp_valid,
    output logic        m_icb_rsp_ready
);

    localparam logic [1:0] RESP_OKAY = 2'b00;

    typedef enum logic [2:0] {ST_IDLE, ST_CMD, ST_RSP, ST_BRESP, ST_RRESP} state_t;

    state_t      state;
    logic        aw_vld, w_vld, ar_vld;
    logic [31:0] aw_addr, w_data, ar_addr;
    logic [3:0]  w_strb;
    logic        last_was_wr, cur_is_wr;
    logic        cmd_valid, cmd_read, rsp_ready;
    logic [31:0] cmd_addr, cmd_wdata, rdata;
    logic [3:0]  cmd_wmask;
    logic        bvalid, rvalid;
    logic [1:0]  bresp, rresp;
    logic        wr_ok, rd_ok, pick_wr, take_wr, take_rd;
    logic        unused_prot;

    // The delay parameter only shapes simulation timing and builds no hardware.
    if (simulation_delay < 0.0) begin : g_neg_delay
    end

    assign unused_prot = ^{s_axi_awprot, s_axi_arprot};

    // On a conflict, serve the opposite of whatever went out last.
    assign wr_ok   = aw_vld & w_vld;
    assign rd_ok   = ar_vld;
    assign pick_wr = wr_ok & (~rd_ok | ~last_was_wr);
    assign take_wr = (state == ST_IDLE) & pick_wr;
    assign take_rd = (state == ST_IDLE) & rd_ok & ~pick_wr;

    assign s_axi_awready   = ~aw_vld;
    assign s_axi_wready    = ~w_vld;
    assign s_axi_arready   = ~ar_vld;
    assign s_axi_bresp     = bresp;
    assign s_axi_bvalid    = bvalid;
    assign s_axi_rdata     = rdata;
    assign s_axi_rresp     = rresp;
    assign s_axi_rvalid    = rvalid;
    assign m_icb_cmd_addr  = cmd_addr;
    assign m_icb_cmd_read  = cmd_read;
    assign m_icb_cmd_wdata = cmd_wdata;
    assign m_icb_cmd_wmask = cmd_wmask;
    assign m_icb_cmd_valid = cmd_valid;
    assign m_icb_rsp_ready = rsp_ready;

    // A buffer cannot be filled and drained in the same edge: draining needs vld=1, which holds ready low.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_vld  <= 1'b0;
            aw_addr <= '0;
            w_vld   <= 1'b0;
            w_data  <= '0;
            w_strb  <= '0;
            ar_vld  <= 1'b0;
            ar_addr <= '0;
        end else begin
            if (s_axi_awvalid && !aw_vld) begin
                aw_vld  <= 1'b1;
                aw_addr <= s_axi_awaddr;
            end else if (take_wr) begin
                aw_vld <= 1'b0;
            end
            if (s_axi_wvalid && !w_vld) begin
                w_vld  <= 1'b1;
                w_data <= s_axi_wdata;
                w_strb <= s_axi_wstrb;
            end else if (take_wr) begin
                w_vld <= 1'b0;
            end
            if (s_axi_arvalid && !ar_vld) begin
                ar_vld  <= 1'b1;
                ar_addr <= s_axi_araddr;
            end else if (take_rd) begin
                ar_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= ST_IDLE;
            last_was_wr <= 1'b0;
            cur_is_wr   <= 1'b0;
            cmd_valid   <= 1'b0;
            cmd_addr    <= '0;
            cmd_read    <= 1'b0;
            cmd_wdata   <= '0;
            cmd_wmask   <= '0;
            rsp_ready   <= 1'b0;
            bvalid      <= 1'b0;
            bresp       <= '0;
            rvalid      <= 1'b0;
            rresp       <= '0;
            rdata       <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (take_wr) begin
                        cmd_addr    <= aw_addr;
                        cmd_read    <= 1'b0;
                        cmd_wdata   <= w_data;
                        cmd_wmask   <= w_strb;
                        cmd_valid   <= 1'b1;
                        cur_is_wr   <= 1'b1;
                        last_was_wr <= 1'b1;
                        state       <= ST_CMD;
                    end else if (take_rd) begin
                        cmd_addr    <= ar_addr;
                        cmd_read    <= 1'b1;
                        cmd_wdata   <= '0;
                        cmd_wmask   <= '0;
                        cmd_valid   <= 1'b1;
                        cur_is_wr   <= 1'b0;
                        last_was_wr <= 1'b0;
                        state       <= ST_CMD;
                    end
                end
                ST_CMD: begin
                    if (m_icb_cmd_ready) begin
                        cmd_valid <= 1'b0;
                        rsp_ready <= 1'b1;
                        state     <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (m_icb_rsp_valid) begin
                        rsp_ready <= 1'b0;
                        if (cur_is_wr) begin
                            bresp  <= m_icb_rsp_err ? slverr_code : RESP_OKAY;
                            bvalid <= 1'b1;
                            state  <= ST_BRESP;
                        end else begin
                            rdata  <= m_icb_rsp_rdata;
                            rresp  <= m_icb_rsp_err ? slverr_code : RESP_OKAY;
                            rvalid <= 1'b1;
                            state  <= ST_RRESP;
                        end
                    end
                end
                ST_BRESP: begin
                    if (s_axi_bready) begin
                        bvalid <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                ST_RRESP: begin
                    if (s_axi_rready) begin
                        rvalid <= 1'b0;
                        state  <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_lite_icb_bridge.sv
// Directed bench for axi_lite_icb_bridge: drives AXI-Lite transactions against a
// small ICB slave model and compares responses and issued commands to hand-computed values.
module tb_axi_lite_icb_bridge;

    logic        clk;
    logic        resetn;
    logic [31:0] s_axi_awaddr;
    logic [2:0]  s_axi_awprot;
    logic        s_axi_awvalid, s_axi_awready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_wvalid, s_axi_wready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_bvalid, s_axi_bready;
    logic [31:0] s_axi_araddr;
    logic [2:0]  s_axi_arprot;
    logic        s_axi_arvalid, s_axi_arready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        s_axi_rvalid, s_axi_rready;
    logic [31:0] m_icb_cmd_addr, m_icb_cmd_wdata;
    logic        m_icb_cmd_read;
    logic [3:0]  m_icb_cmd_wmask;
    logic        m_icb_cmd_valid, m_icb_cmd_ready;
    logic [31:0] m_icb_rsp_rdata;
    logic        m_icb_rsp_err, m_icb_rsp_valid, m_icb_rsp_ready;

    logic        slv_ready;
    logic [31:0] slv_rdata;
    logic        slv_err;

    typedef struct {
        logic [31:0] addr;
        logic        rd;
        logic [31:0] wdata;
        logic [3:0]  wmask;
    } cmd_t;
    cmd_t cmd_q[$];

    int n_checks = 0;
    int n_errors = 0;

    axi_lite_icb_bridge #(.simulation_delay(1), .slverr_code(2'b10)) dut (
        .clk(clk), .resetn(resetn),
        .s_axi_awaddr(s_axi_awaddr), .s_axi_awprot(s_axi_awprot),
        .s_axi_awvalid(s_axi_awvalid), .s_axi_awready(s_axi_awready),
        .s_axi_wdata(s_axi_wdata), .s_axi_wstrb(s_axi_wstrb),
        .s_axi_wvalid(s_axi_wvalid), .s_axi_wready(s_axi_wready),
        .s_axi_bresp(s_axi_bresp), .s_axi_bvalid(s_axi_bvalid), .s_axi_bready(s_axi_bready),
        .s_axi_araddr(s_axi_araddr), .s_axi_arprot(s_axi_arprot),
        .s_axi_arvalid(s_axi_arvalid), .s_axi_arready(s_axi_arready),
        .s_axi_rdata(s_axi_rdata), .s_axi_rresp(s_axi_rresp),
        .s_axi_rvalid(s_axi_rvalid), .s_axi_rready(s_axi_rready),
        .m_icb_cmd_addr(m_icb_cmd_addr), .m_icb_cmd_read(m_icb_cmd_read),
        .m_icb_cmd_wdata(m_icb_cmd_wdata), .m_icb_cmd_wmask(m_icb_cmd_wmask),
        .m_icb_cmd_valid(m_icb_cmd_valid), .m_icb_cmd_ready(m_icb_cmd_ready),
        .m_icb_rsp_rdata(m_icb_rsp_rdata), .m_icb_rsp_err(m_icb_rsp_err),
        .m_icb_rsp_valid(m_icb_rsp_valid), .m_icb_rsp_ready(m_icb_rsp_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign m_icb_cmd_ready = slv_ready;

    // ICB slave: logs every accepted command and answers one cycle later.
    initial begin
        bit cfire, rfire;
        m_icb_rsp_valid = 1'b0;
        m_icb_rsp_rdata = '0;
        m_icb_rsp_err   = 1'b0;
        forever begin
            @(negedge clk);
            cfire = resetn && m_icb_cmd_valid && slv_ready;
            rfire = resetn && m_icb_rsp_ready && m_icb_rsp_valid;
            if (cfire)
                cmd_q.push_back('{m_icb_cmd_addr, m_icb_cmd_read, m_icb_cmd_wdata, m_icb_cmd_wmask});
            @(posedge clk);
            #1;
            if (rfire) m_icb_rsp_valid = 1'b0;
            if (cfire) begin
                m_icb_rsp_valid = 1'b1;
                m_icb_rsp_rdata = slv_rdata;
                m_icb_rsp_err   = slv_err;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic send(input bit do_aw, input bit do_w, input bit do_ar,
                        input logic [31:0] awaddr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input logic [31:0] araddr, input string tag);
        int  n = 0;
        bit  aw_go, w_go, ar_go;
        s_axi_awaddr  = awaddr;
        s_axi_wdata   = wdata;
        s_axi_wstrb   = wstrb;
        s_axi_araddr  = araddr;
        s_axi_awvalid = do_aw;
        s_axi_wvalid  = do_w;
        s_axi_arvalid = do_ar;
        while ((s_axi_awvalid || s_axi_wvalid || s_axi_arvalid) && n < 30) begin
            @(negedge clk);
            aw_go = s_axi_awvalid && s_axi_awready;
            w_go  = s_axi_wvalid && s_axi_wready;
            ar_go = s_axi_arvalid && s_axi_arready;
            @(posedge clk);
            #1;
            if (aw_go) s_axi_awvalid = 1'b0;
            if (w_go)  s_axi_wvalid  = 1'b0;
            if (ar_go) s_axi_arvalid = 1'b0;
            n++;
        end
        check({tag, ".accepted"}, {s_axi_awvalid, s_axi_wvalid, s_axi_arvalid}, 0);
        s_axi_awvalid = 1'b0;
        s_axi_wvalid  = 1'b0;
        s_axi_arvalid = 1'b0;
    endtask

    task automatic expect_cmd(input string tag, input logic [31:0] addr, input logic rd,
                              input logic [31:0] wdata, input logic [3:0] wmask);
        int   n = 0;
        cmd_t c;
        while (cmd_q.size() == 0 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, ".issued"}, (cmd_q.size() != 0), 1);
        if (cmd_q.size() != 0) begin
            c = cmd_q.pop_front();
            check({tag, ".addr"},  c.addr,  addr);
            check({tag, ".read"},  c.rd,    rd);
            check({tag, ".wdata"}, c.wdata, wdata);
            check({tag, ".wmask"}, c.wmask, wmask);
        end
    endtask

    task automatic wait_resp(input bit is_rd, input string tag);
        int n = 0;
        @(negedge clk);
        while ((is_rd ? s_axi_rvalid : s_axi_bvalid) !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check({tag, ".valid"}, is_rd ? s_axi_rvalid : s_axi_bvalid, 1);
    endtask

    task automatic ack(input bit is_rd);
        if (is_rd) s_axi_rready = 1'b1;
        else       s_axi_bready = 1'b1;
        @(posedge clk);
        #1;
        s_axi_rready = 1'b0;
        s_axi_bready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        resetn = 1'b0;
        s_axi_awaddr = '0; s_axi_awprot = '0; s_axi_awvalid = 1'b0;
        s_axi_wdata = '0;  s_axi_wstrb = '0;  s_axi_wvalid = 1'b0;
        s_axi_bready = 1'b0;
        s_axi_araddr = '0; s_axi_arprot = '0; s_axi_arvalid = 1'b0;
        s_axi_rready = 1'b0;
        slv_ready = 1'b0; slv_rdata = '0; slv_err = 1'b0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst.awready", s_axi_awready, 1);
        check("rst.wready",  s_axi_wready,  1);
        check("rst.arready", s_axi_arready, 1);
        check("rst.bvalid",  s_axi_bvalid,  0);
        check("rst.rvalid",  s_axi_rvalid,  0);
        check("rst.bresp",   s_axi_bresp,   0);
        check("rst.rresp",   s_axi_rresp,   0);
        check("rst.rdata",   s_axi_rdata,   0);
        check("rst.cmd_valid", m_icb_cmd_valid, 0);
        check("rst.cmd_addr",  m_icb_cmd_addr,  0);
        check("rst.rsp_ready", m_icb_rsp_ready, 0);
        resetn = 1'b1;
        @(posedge clk);
        #1;
        slv_ready = 1'b1;

        // 1: AW+W together, exact latency through to bvalid
        send(1, 1, 0, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 32'h0, "t1");
        @(negedge clk);
        check("t1.cmd_valid_n", m_icb_cmd_valid, 0);
        @(negedge clk);
        check("t1.cmd_valid", m_icb_cmd_valid, 1);
        check("t1.cmd_addr",  m_icb_cmd_addr,  32'h0000_0010);
        check("t1.cmd_read",  m_icb_cmd_read,  0);
        check("t1.cmd_wdata", m_icb_cmd_wdata, 32'hDEAD_BEEF);
        check("t1.cmd_wmask", m_icb_cmd_wmask, 4'hF);
        @(negedge clk);
        check("t1.rsp_ready", m_icb_rsp_ready, 1);
        @(negedge clk);
        check("t1.bvalid", s_axi_bvalid, 1);
        check("t1.bresp",  s_axi_bresp,  2'b00);
        ack(0);
        expect_cmd("t1.log", 32'h0000_0010, 1'b0, 32'hDEAD_BEEF, 4'hF);

        // 2: W three cycles ahead of AW
        send(0, 1, 0, 32'h0, 32'h5555_AAAA, 4'b0011, 32'h0, "t2w");
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("t2.no_cmd", m_icb_cmd_valid, 0);
        end
        check("t2.wready_full", s_axi_wready, 0);
        @(posedge clk);
        #1;
        send(1, 0, 0, 32'h0000_0020, 32'h0, 4'h0, 32'h0, "t2aw");
        expect_cmd("t2", 32'h0000_0020, 1'b0, 32'h5555_AAAA, 4'b0011);
        wait_resp(0, "t2");
        check("t2.bresp", s_axi_bresp, 2'b00);
        ack(0);

        // 3: read returning err=1
        slv_rdata = 32'h1234_5678;
        slv_err   = 1'b1;
        send(0, 0, 1, 32'h0, 32'h0, 4'h0, 32'h0000_0004, "t3");
        expect_cmd("t3", 32'h0000_0004, 1'b1, 32'h0, 4'h0);
        wait_resp(1, "t3");
        check("t3.rdata", s_axi_rdata, 32'h1234_5678);
        check("t3.rresp", s_axi_rresp, 2'b10);
        ack(1);
        slv_err = 1'b0;

        // 4: AW, W, AR together after reset -> write first; after a lone write the read wins
        do_reset();
        slv_rdata = 32'hA0A0_0200;
        send(1, 1, 1, 32'h0000_0100, 32'h1111_2222, 4'hF, 32'h0000_0200, "t4a");
        expect_cmd("t4a.wr", 32'h0000_0100, 1'b0, 32'h1111_2222, 4'hF);
        wait_resp(0, "t4a");
        check("t4a.no_rd_yet", cmd_q.size(), 0);
        ack(0);
        expect_cmd("t4a.rd", 32'h0000_0200, 1'b1, 32'h0, 4'h0);
        wait_resp(1, "t4a");
        check("t4a.rdata", s_axi_rdata, 32'hA0A0_0200);
        ack(1);
        send(1, 1, 0, 32'h0000_0104, 32'h3333_4444, 4'h1, 32'h0, "t4b");
        expect_cmd("t4b.wr", 32'h0000_0104, 1'b0, 32'h3333_4444, 4'h1);
        wait_resp(0, "t4b");
        ack(0);
        slv_rdata = 32'hB0B0_0208;
        send(1, 1, 1, 32'h0000_0108, 32'h5555_6666, 4'h8, 32'h0000_0208, "t4c");
        expect_cmd("t4c.rd", 32'h0000_0208, 1'b1, 32'h0, 4'h0);
        wait_resp(1, "t4c");
        check("t4c.rdata", s_axi_rdata, 32'hB0B0_0208);
        check("t4c.no_wr_yet", cmd_q.size(), 0);
        ack(1);
        expect_cmd("t4c.wr", 32'h0000_0108, 1'b0, 32'h5555_6666, 4'h8);
        wait_resp(0, "t4c");
        ack(0);

        // 5: rready held low while a second AR arrives
        slv_rdata = 32'hCAFE_0005;
        send(0, 0, 1, 32'h0, 32'h0, 4'h0, 32'h0000_0030, "t5a");
        expect_cmd("t5a", 32'h0000_0030, 1'b1, 32'h0, 4'h0);
        wait_resp(1, "t5a");
        check("t5.arready_free", s_axi_arready, 1);
        @(posedge clk);
        #1;
        slv_rdata = 32'hCAFE_0034;
        send(0, 0, 1, 32'h0, 32'h0, 4'h0, 32'h0000_0034, "t5b");
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t5.arready_full", s_axi_arready, 0);
            check("t5.cmd_blocked", m_icb_cmd_valid, 0);
        end
        check("t5.rvalid_held", s_axi_rvalid, 1);
        check("t5.rdata_held", s_axi_rdata, 32'hCAFE_0005);
        check("t5.no_second_cmd", cmd_q.size(), 0);
        ack(1);
        expect_cmd("t5b", 32'h0000_0034, 1'b1, 32'h0, 4'h0);
        wait_resp(1, "t5b");
        check("t5b.rdata", s_axi_rdata, 32'hCAFE_0034);
        ack(1);

        // 6: asynchronous reset while stuck in CMD
        slv_ready = 1'b0;
        send(1, 1, 0, 32'h0000_0040, 32'h7777_8888, 4'hF, 32'h0, "t6a");
        n = 0;
        while (!m_icb_cmd_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("t6.cmd_valid", m_icb_cmd_valid, 1);
        #2;
        resetn = 1'b0;
        #1;
        check("t6.async_cmd_valid", m_icb_cmd_valid, 0);
        check("t6.async_bvalid", s_axi_bvalid, 0);
        check("t6.async_rvalid", s_axi_rvalid, 0);
        check("t6.async_cmd_addr", m_icb_cmd_addr, 0);
        check("t6.async_awready", s_axi_awready, 1);
        @(negedge clk);
        resetn = 1'b1;
        check("t6.no_cmd_logged", cmd_q.size(), 0);
        @(posedge clk);
        #1;
        slv_ready = 1'b1;
        send(1, 1, 0, 32'h0000_0044, 32'h0BAD_F00D, 4'hC, 32'h0, "t6b");
        expect_cmd("t6b", 32'h0000_0044, 1'b0, 32'h0BAD_F00D, 4'hC);
        wait_resp(0, "t6b");
        check("t6b.bresp", s_axi_bresp, 2'b00);
        ack(0);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
